// File: rtl/lcd_byte_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer_if
//   Request side of the LCD byte writer: the CPU register decode (master)
//   hands command/data bytes to the writer (slave) over a valid/ready
//   handshake. A byte is transferred on a clock edge where i_vld & o_rdy.
//
// Signals (names seen from the writer's side)
//   i_vld    master->slave  byte request valid, held until o_rdy
//   i_rs     master->slave  0 = command, 1 = data
//   i_data   master->slave  byte to write
//   o_rdy    slave->master  writer idle and accepting
//   o_busy   slave->master  ~o_rdy
// ---------------------------------------------------------------------------
interface lcd_byte_writer_if;
  logic       i_vld;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_rdy;
  logic       o_busy;

  modport master (
    output i_vld,
    output i_rs,
    output i_data,
    input  o_rdy,
    input  o_busy
  );

  modport slave (
    input  i_vld,
    input  i_rs,
    input  i_data,
    output o_rdy,
    output o_busy
  );
endinterface

// File: rtl/lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer
//   Hardware end of the LCD port. Accepts command/data bytes over a
//   valid/ready handshake and produces HD44780-style write timing:
//   RS/DATA setup, EN pulse, hold, then an execution wait before the next
//   byte is accepted. Clear/home commands get the long execution wait.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   req          slave side of lcd_byte_writer_if (i_vld/i_rs/i_data in,
//                o_rdy/o_busy out)
//   o_lcd_on     LCD power/backlight enable (1 from the first cycle after reset)
//   o_lcd_en     LCD EN strobe
//   o_lcd_rs     LCD RS
//   o_lcd_rw     LCD RW, tied 0 (write only)
//   o_lcd_data   LCD data bus
//   o_io_lcd     packed view {ON,20'b0,EN,RS,RW,DATA} (bits 31,10,9,8,7:0)
//
// Configuration
//   LCD_INIT_EN  when defined, reset enters a power-up wait of T_PWR_CYC and
//                then writes the init sequence 38,38,38,0C,01,06 before the
//                request port is opened (o_rdy stays 0 until then).
//                When undefined, there is no power-up state and no ROM.
// ---------------------------------------------------------------------------
module lcd_byte_writer #(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 4,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000,
  parameter int unsigned T_PWR_CYC   = 750000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  lcd_byte_writer_if.slave    req,
  output logic                o_lcd_on,
  output logic                o_lcd_en,
  output logic                o_lcd_rs,
  output logic                o_lcd_rw,
  output logic [7:0]          o_lcd_data,
  output logic [31:0]         o_io_lcd
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One down-counter serves every state, so it is sized for the largest delay.
  localparam int unsigned MAX_CYC = max_u(max_u(max_u(T_SETUP_CYC, T_EN_CYC),
                                                max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                          max_u(T_LONG_CYC, T_PWR_CYC));
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG_CYC - 1);
`ifdef LCD_INIT_EN
  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(T_PWR_CYC - 1);
  localparam logic [2:0]       INIT_LAST = 3'd5;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;  // function set, repeated for wake-up
      3'd3:             return 8'h0C;  // display on, cursor off
      3'd4:             return 8'h01;  // clear (long wait)
      default:          return 8'h06;  // entry mode: increment
    endcase
  endfunction
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_INIT_EN
    , ST_PWR
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rs_q,    rs_d;
  logic [7:0]       data_q,  data_d;
  logic             en_q,    en_d;
  logic             rdy_q,   rdy_d;
  logic             on_q,    on_d;
`ifdef LCD_INIT_EN
  logic             init_pending_q, init_pending_d;
  logic [2:0]       init_idx_q,     init_idx_d;
`endif

  logic       start;
  logic       start_rs;
  logic [7:0] start_data;
  logic       is_long;

  // Commands 0x00..0x03 (clear/home and the 0x00 alias) need the long wait;
  // data writes never do.
  assign is_long = ~rs_q & (data_q[7:2] == 6'd0);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    data_d     = data_q;
    on_d       = 1'b1;
`ifdef LCD_INIT_EN
    init_pending_d = init_pending_q;
    init_idx_d     = init_idx_q;
    // Internal ROM requests take priority; rdy_q is 0 while they are pending.
    start      = init_pending_q | (req.i_vld & rdy_q);
    start_rs   = init_pending_q ? 1'b0 : req.i_rs;
    start_data = init_pending_q ? init_rom(init_idx_q) : req.i_data;
`else
    start      = req.i_vld & rdy_q;
    start_rs   = req.i_rs;
    start_data = req.i_data;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rs_d    = start_rs;
          data_d  = start_data;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
`ifdef LCD_INIT_EN
          if (init_pending_q) begin
            init_idx_d = init_idx_q + 3'd1;
            // Clearing pending on the last issue lets o_rdy rise only when
            // that write's WAIT finishes.
            if (init_idx_q == INIT_LAST) init_pending_d = 1'b0;
          end
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = EN_LD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = is_long ? LONG_LD : EXEC_LD;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef LCD_INIT_EN
      ST_PWR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered and
    // line up with the state they belong to.
    en_d  = (state_d == ST_PULSE);
`ifdef LCD_INIT_EN
    rdy_d = (state_d == ST_IDLE) & ~init_pending_d;
`else
    rdy_d = (state_d == ST_IDLE);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
`ifdef LCD_INIT_EN
      state_q        <= ST_PWR;
      cnt_q          <= PWR_LD;
      rdy_q          <= 1'b0;
      init_pending_q <= 1'b1;
      init_idx_q     <= 3'd0;
`else
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rdy_q          <= 1'b1;
`endif
      rs_q           <= 1'b0;
      data_q         <= 8'h00;
      en_q           <= 1'b0;
      on_q           <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rdy_q          <= rdy_d;
`ifdef LCD_INIT_EN
      init_pending_q <= init_pending_d;
      init_idx_q     <= init_idx_d;
`endif
      rs_q           <= rs_d;
      data_q         <= data_d;
      en_q           <= en_d;
      on_q           <= on_d;
    end
  end

  assign req.o_rdy  = rdy_q;
  assign req.o_busy = ~rdy_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_io_lcd   = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule
